// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
// The reset PC lives here so exception/boot logic can reuse the same value.
package pc_fetch_unit_pkg;

    // Word address loaded on reset (byte address 0x0000_3000)
    localparam logic [29:0] PC_RESET_DEFAULT = 30'h0000_0C00;

    // Fetch sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_HOLD     = 2'd1,
        ST_WAIT_NPC = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/ack, IR handoff to decode,
// next-PC feedback and the handoff counter.
interface pc_fetch_unit_if;
    logic [31:2] im_addr;
    logic        im_req;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] ir;
    logic [31:2] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:2] npc;
    logic        npc_valid;
    logic [31:0] fetch_cnt;

    // Fetch unit side
    modport master (
        output im_addr, im_req, ir, ir_pc, ir_valid, fetch_cnt,
        input  im_ack, im_rdata, ir_ready, npc, npc_valid
    );

    // Memory / decode / next-PC side
    modport slave (
        input  im_addr, im_req, ir, ir_pc, ir_valid, fetch_cnt,
        output im_ack, im_rdata, ir_ready, npc, npc_valid
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, requests a word from instruction
// memory, latches it into IR and hands it to decode, then waits for the
// next-PC unit before fetching again. Every output comes straight from a
// register, so no input reaches an output combinationally.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [29:0] RESET_PC = PC_RESET_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_unit_if.master bus
);

    fetch_state_t r_state;
    logic [29:0]  r_pc;
    logic         r_im_req;
    logic [31:0]  r_ir;
    logic [29:0]  r_ir_pc;
    logic         r_ir_valid;
    logic [31:0]  r_fetch_cnt;

    // im_req is a register rather than a decode of state so that it stays low
    // for the whole time rst is held, without a path from rst to the output.
    // An ack is honored only while that register is high.

    // Fetch sequencer: PC, request, IR capture, handoff and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_pc        <= RESET_PC;
            r_im_req    <= 1'b0;
            r_ir        <= '0;
            r_ir_pc     <= '0;
            r_ir_valid  <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (r_im_req && bus.im_ack) begin
                        r_ir       <= bus.im_rdata;
                        r_ir_pc    <= r_pc;
                        r_ir_valid <= 1'b1;
                        r_im_req   <= 1'b0;
                        r_state    <= ST_HOLD;
                    end else begin
                        r_im_req <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.ir_ready) begin
                        r_ir_valid  <= 1'b0;
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
                        if (bus.npc_valid) begin
                            r_pc     <= bus.npc;
                            r_im_req <= 1'b1;
                            r_state  <= ST_FETCH;
                        end else begin
                            r_state <= ST_WAIT_NPC;
                        end
                    end
                end
                ST_WAIT_NPC: begin
                    if (bus.npc_valid) begin
                        r_pc     <= bus.npc;
                        r_im_req <= 1'b1;
                        r_state  <= ST_FETCH;
                    end
                end
                default: begin
                    r_state    <= ST_FETCH;
                    r_im_req   <= 1'b0;
                    r_ir_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.im_addr   = r_pc;
    assign bus.im_req    = r_im_req;
    assign bus.ir        = r_ir;
    assign bus.ir_pc     = r_ir_pc;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed phases with a scoreboard monitor
// that checks every accepted fetch address and every IR handoff.
module tb_pc_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned errors = 0;
    int unsigned checks = 0;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(30'h0000_0C00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: fixed word when requested, otherwise address-derived data
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_data = '0;
    logic        npc_follow = 1'b0;
    logic [29:0] npc_reg = '0;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {2'b00, a} ^ 32'h1234_0000;
    endfunction

    assign bus.im_rdata = use_fixed ? fixed_data : mem_word(bus.im_addr);
    assign bus.npc      = npc_follow ? (bus.ir_pc + 30'd1) : npc_reg;

    typedef struct {
        logic [31:0] ir;
        logic [29:0] pc;
        logic [31:0] cnt;
    } ir_exp_t;

    logic [29:0] addr_q[$];
    ir_exp_t     ir_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [29:0] a, input logic [31:0] d, input logic [31:0] cnt);
        ir_exp_t e;
        addr_q.push_back(a);
        e.ir  = d;
        e.pc  = a;
        e.cnt = cnt;
        ir_q.push_back(e);
    endtask

    // Monitor: compare accepted fetches and IR handoffs against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.im_req && bus.im_ack) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_fetch", {2'b00, bus.im_addr}, 32'hFFFF_FFFF);
                end else begin
                    check("fetch_addr", {2'b00, bus.im_addr}, {2'b00, addr_q.pop_front()});
                end
            end
            if (bus.ir_valid && bus.ir_ready) begin
                if (ir_q.size() == 0) begin
                    check("unexpected_handoff", bus.ir, 32'hFFFF_FFFF);
                end else begin
                    ir_exp_t e;
                    e = ir_q.pop_front();
                    check("handoff_ir", bus.ir, e.ir);
                    check("handoff_ir_pc", {2'b00, bus.ir_pc}, {2'b00, e.pc});
                    check("handoff_cnt", bus.fetch_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [29:0] exp_addr [5];

    initial begin
        bus.im_ack    = 1'b1;
        bus.ir_ready  = 1'b0;
        bus.npc_valid = 1'b0;

        // Reset held two cycles with im_ack high
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_im_req", {31'd0, bus.im_req}, 32'd0);
            check("rst_im_addr", {2'b00, bus.im_addr}, 32'h0000_0C00);
            check("rst_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
            check("rst_fetch_cnt", bus.fetch_cnt, 32'd0);
        end
        bus.im_ack = 1'b0;
        rst = 1'b0;
        check("rel_im_req_low", {31'd0, bus.im_req}, 32'd0);
        tick();
        check("first_im_req", {31'd0, bus.im_req}, 32'd1);
        check("first_im_addr", {2'b00, bus.im_addr}, 32'h0000_0C00);

        // Zero-wait stream, npc = PC+1 coincident with ready
        push_fetch(30'h0C00, mem_word(30'h0C00), 32'd0);
        push_fetch(30'h0C01, mem_word(30'h0C01), 32'd1);
        push_fetch(30'h0C02, mem_word(30'h0C02), 32'd2);
        exp_addr = '{30'h0C00, 30'h0C01, 30'h0C01, 30'h0C02, 30'h0C02};
        npc_follow    = 1'b1;
        bus.im_ack    = 1'b1;
        bus.ir_ready  = 1'b1;
        bus.npc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stream_addr", {2'b00, bus.im_addr}, {2'b00, exp_addr[i]});
            check("stream_req", {31'd0, bus.im_req}, {31'd0, (i % 2) == 1});
        end
        bus.im_ack    = 1'b0;
        bus.ir_ready  = 1'b0;
        bus.npc_valid = 1'b0;
        npc_follow    = 1'b0;
        check("stream_cnt", bus.fetch_cnt, 32'd2);

        // Decode backpressure with an ignored npc pulse
        for (int i = 0; i < 5; i++) begin
            npc_reg       = 30'h0ABC;
            bus.npc_valid = (i == 2);
            tick();
            check("bp_ir", bus.ir, mem_word(30'h0C02));
            check("bp_ir_pc", {2'b00, bus.ir_pc}, 32'h0000_0C02);
            check("bp_pc", {2'b00, bus.im_addr}, 32'h0000_0C02);
            check("bp_ir_valid", {31'd0, bus.ir_valid}, 32'd1);
            check("bp_im_req", {31'd0, bus.im_req}, 32'd0);
        end
        bus.npc_valid = 1'b0;
        bus.ir_ready  = 1'b1;
        tick();
        bus.ir_ready  = 1'b0;
        check("wait_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
        check("wait_cnt", bus.fetch_cnt, 32'd3);
        check("wait_pc", {2'b00, bus.im_addr}, 32'h0000_0C02);
        check("wait_ir_kept", bus.ir, mem_word(30'h0C02));

        // Branch redirect two cycles later, then a 3-cycle memory wait
        for (int i = 0; i < 2; i++) begin
            tick();
            check("redir_idle_req", {31'd0, bus.im_req}, 32'd0);
        end
        npc_reg       = 30'h0D10;
        bus.npc_valid = 1'b1;
        use_fixed     = 1'b1;
        fixed_data    = 32'h2408_0005;
        push_fetch(30'h0D10, 32'h2408_0005, 32'd3);
        tick();
        bus.npc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("memwait_req", {31'd0, bus.im_req}, 32'd1);
            check("memwait_addr", {2'b00, bus.im_addr}, 32'h0000_0D10);
            if (i < 3) tick();
        end
        bus.im_ack = 1'b1;
        tick();
        bus.im_ack = 1'b0;
        check("ack_ir_valid", {31'd0, bus.ir_valid}, 32'd1);
        check("ack_ir", bus.ir, 32'h2408_0005);
        check("ack_ir_pc", {2'b00, bus.ir_pc}, 32'h0000_0D10);
        check("ack_req_drop", {31'd0, bus.im_req}, 32'd0);
        use_fixed = 1'b0;

        // Reset mid-operation overrides a coincident handoff
        rst           = 1'b1;
        bus.ir_ready  = 1'b1;
        bus.npc_valid = 1'b1;
        ir_q.delete();
        tick();
        check("mrst_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
        check("mrst_cnt", bus.fetch_cnt, 32'd0);
        check("mrst_req", {31'd0, bus.im_req}, 32'd0);
        check("mrst_addr", {2'b00, bus.im_addr}, 32'h0000_0C00);
        rst           = 1'b0;
        bus.ir_ready  = 1'b0;
        bus.npc_valid = 1'b0;
        tick();
        check("mrst_restart_req", {31'd0, bus.im_req}, 32'd1);

        // Counter wrap: preload the counter, then one handoff
        force dut.r_fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_fetch_cnt;
        check("wrap_preload", bus.fetch_cnt, 32'hFFFF_FFFF);
        push_fetch(30'h0C00, mem_word(30'h0C00), 32'hFFFF_FFFF);
        bus.im_ack = 1'b1;
        tick();
        bus.im_ack   = 1'b0;
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        check("wrap_cnt", bus.fetch_cnt, 32'd0);
        check("wrap_ir_valid", {31'd0, bus.ir_valid}, 32'd0);

        tick();
        check("addr_q_empty", addr_q.size(), 32'd0);
        check("ir_q_empty", ir_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
